// File: rtl/lfsr_arbiter.sv
// Shares one 128-bit LFSR between a plaintext and a key generator. A granted requester
// gets STEPS advances of the LFSR, one captured word and a one-cycle ack.
module lfsr_arbiter #(
  parameter int unsigned STEPS = 1
) (
  input  logic         clk,
  input  logic         rst,
  // Handshake: req[i] is a level held until ack[i]; ack[i] is a one-cycle pulse during
  // which data_out is valid for requester i; the requester drops req the cycle after.
  input  logic [1:0]   req,
  output logic [1:0]   ack,
  output logic [127:0] data_out,
  output logic         lfsr_require,
  input  logic [127:0] lfsr_data,
  output logic         busy,
  output logic [15:0]  word_cnt,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic [4:0] STEP_LOAD = 5'(STEPS);

  state_t         state_q, state_d;
  logic [4:0]     step_cnt_q, step_cnt_d;
  logic           owner_q, owner_d;
  logic           last_owner_q, last_owner_d;
  logic [127:0]   data_q, data_d;
  logic [15:0]    word_cnt_q, word_cnt_d;
  logic           winner;

  // Round-robin: a lone request wins; on a tie the one that was not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_owner_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    word_cnt_d   = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          owner_d    = winner;
          step_cnt_d = STEP_LOAD;
          state_d    = STEP;
        end
      end
      STEP: begin
        step_cnt_d = step_cnt_q - 5'd1;
        if (step_cnt_q == 5'd1) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // lfsr_data already reflects every advance requested during STEP.
        data_d       = lfsr_data;
        last_owner_d = owner_q;
        state_d      = ACK;
      end
      ACK: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      step_cnt_q   <= 5'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      data_q       <= 128'd0;
      word_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      data_q       <= data_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // Outputs are decoded from registered state only; req never reaches them directly.
  assign lfsr_require = (state_q == STEP);
  assign busy         = (state_q != IDLE);
  assign ack          = (state_q == ACK) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign data_out     = data_q;
  assign word_cnt     = word_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter: one instance with STEPS=1, one with STEPS=4, each fed
// by its own bench-side LFSR that advances only on lfsr_require.
module tb_lfsr_arbiter;

  localparam logic [127:0] SEED1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] SEED4 = 128'hdead_beef_0bad_f00d_1357_9bdf_2468_ace0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lfsr_en = 1'b0;
  logic         mon_en = 1'b0;
  int           tests = 0;
  int           fails = 0;

  logic [1:0]   req1 = 2'b00, ack1, st1;
  logic [127:0] data1, lfsr1 = SEED1, exp1 = SEED1;
  logic         lreq1, busy1;
  logic [15:0]  wc1;

  logic [1:0]   req4 = 2'b00, ack4, st4;
  logic [127:0] data4, lfsr4 = SEED4, exp4 = SEED4;
  logic         lreq4, busy4;
  logic [15:0]  wc4;

  // ---------------- clock / reset / LFSR stand-ins ----------------
  always #5 clk = ~clk;

  function automatic logic [127:0] lfsr_next(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98]};
  endfunction

  always @(posedge clk) begin
    if (lfsr_en && lreq1) lfsr1 <= lfsr_next(lfsr1);
    if (lfsr_en && lreq4) lfsr4 <= lfsr_next(lfsr4);
  end

  lfsr_arbiter #(.STEPS(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .ack(ack1), .data_out(data1),
    .lfsr_require(lreq1), .lfsr_data(lfsr1), .busy(busy1), .word_cnt(wc1),
    .dbg_state(st1)
  );

  lfsr_arbiter #(.STEPS(4)) u4 (
    .clk(clk), .rst(rst), .req(req4), .ack(ack4), .data_out(data4),
    .lfsr_require(lreq4), .lfsr_data(lfsr4), .busy(busy4), .word_cnt(wc4),
    .dbg_state(st4)
  );

  // Invariants watched on every cycle once out of the first reset.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (ack1 === 2'b11 || ack4 === 2'b11) begin
        fails++;
        $display("FAIL mon_ack_11 got ack1=%b ack4=%b exp never 11", ack1, ack4);
      end
      tests++;
      if ((lreq1 && !busy1) || (lreq4 && !busy4)) begin
        fails++;
        $display("FAIL mon_require_idle got lreq1=%b busy1=%b lreq4=%b busy4=%b", lreq1, busy1, lreq4, busy4);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req1 = 2'b00; req4 = 2'b00;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack1, lreq1, busy1, st1} !== 6'b0 || data1 !== 128'd0 || wc1 !== 16'd0) begin
      fails++;
      $display("FAIL reset_u1 got ack=%b req=%b busy=%b st=%0d data=%h wc=%h exp all zero", ack1, lreq1, busy1, st1, data1, wc1);
    end
    tests++;
    if ({ack4, lreq4, busy4, st4} !== 6'b0 || data4 !== 128'd0 || wc4 !== 16'd0) begin
      fails++;
      $display("FAIL reset_u4 got ack=%b req=%b busy=%b st=%0d data=%h wc=%h exp all zero", ack4, lreq4, busy4, st4, data4, wc4);
    end
    rst = 1'b0; lfsr_en = 1'b1; mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [1:0] ea;
    req1 = 2'b01;
    exp1 = lfsr_next(exp1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      ea = (c == 3) ? 2'b01 : 2'b00;
      tests++;
      if (lreq1 !== (c == 1)) begin
        fails++; $display("FAIL single_require c=%0d got %b exp %b", c, lreq1, (c == 1));
      end
      tests++;
      if (ack1 !== ea) begin
        fails++; $display("FAIL single_ack c=%0d got %b exp %b", c, ack1, ea);
      end
      tests++;
      if (busy1 !== (c <= 3)) begin
        fails++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy1, (c <= 3));
      end
      if (c == 3) begin
        tests++;
        if (data1 !== exp1) begin
          fails++; $display("FAIL single_data got %h exp %h", data1, exp1);
        end
      end
      if (c == 4) begin
        req1 = 2'b00;
        tests++;
        if (wc1 !== 16'd1) begin
          fails++; $display("FAIL single_word_cnt got %h exp 0001", wc1);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (data1 !== exp1 || busy1 !== 1'b0) begin
      fails++; $display("FAIL single_hold got data=%h busy=%b exp data=%h busy=0", data1, busy1, exp1);
    end
  endtask

  task automatic test_contention();
    logic [1:0] ea;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req1 = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      ea = 2'b00;
      if (c % 4 == 3) ea = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (ack1 !== ea) begin
        fails++; $display("FAIL contention_ack c=%0d got %b exp %b", c, ack1, ea);
      end
      tests++;
      if (lreq1 !== (c % 4 == 1)) begin
        fails++; $display("FAIL contention_require c=%0d got %b exp %b", c, lreq1, (c % 4 == 1));
      end
      if (ea != 2'b00) begin
        exp1 = lfsr_next(exp1);
        tests++;
        if (data1 !== exp1) begin
          fails++; $display("FAIL contention_data c=%0d got %h exp %h", c, data1, exp1);
        end
      end
      if (c == 16) req1 = 2'b00;
    end
    @(negedge clk);
    tests++;
    if (wc1 !== 16'd4 || busy1 !== 1'b0) begin
      fails++; $display("FAIL contention_word_cnt got wc=%h busy=%b exp wc=0004 busy=0", wc1, busy1);
    end
  endtask

  task automatic test_multi_step();
    logic [1:0] r;
    logic [1:0] ea;
    for (int t = 0; t < 2; t++) begin
      r = (t == 0) ? 2'b10 : 2'b01;
      req4 = r;
      for (int k = 0; k < 4; k++) exp4 = lfsr_next(exp4);
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        ea = (c == 6) ? r : 2'b00;
        tests++;
        if (lreq4 !== (c >= 1 && c <= 4)) begin
          fails++; $display("FAIL multi_require t=%0d c=%0d got %b exp %b", t, c, lreq4, (c <= 4));
        end
        tests++;
        if (ack4 !== ea) begin
          fails++; $display("FAIL multi_ack t=%0d c=%0d got %b exp %b", t, c, ack4, ea);
        end
        if (c == 6) begin
          tests++;
          if (data4 !== exp4) begin
            fails++; $display("FAIL multi_data t=%0d got %h exp %h", t, data4, exp4);
          end
        end
        if (c == 7) begin
          req4 = 2'b00;
          tests++;
          if (wc4 !== 16'(t + 1)) begin
            fails++; $display("FAIL multi_word_cnt t=%0d got %h exp %0d", t, wc4, t + 1);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ea;
    req4 = 2'b01;
    @(negedge clk);
    tests++;
    if (lreq4 !== 1'b1) begin
      fails++; $display("FAIL resetmid_require got %b exp 1", lreq4);
    end
    @(negedge clk);
    rst = 1'b1;
    exp4 = lfsr_next(lfsr_next(exp4));
    @(negedge clk);
    tests++;
    if (busy4 !== 1'b0 || lreq4 !== 1'b0 || ack4 !== 2'b00 || wc4 !== 16'd0 || data4 !== 128'd0) begin
      fails++;
      $display("FAIL resetmid_state got busy=%b req=%b ack=%b wc=%h data=%h exp all zero", busy4, lreq4, ack4, wc4, data4);
    end
    rst = 1'b0; req4 = 2'b00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      tests++;
      if (ack4 !== 2'b00 || busy4 !== 1'b0) begin
        fails++; $display("FAIL resetmid_no_ack c=%0d got ack=%b busy=%b exp 00/0", c, ack4, busy4);
      end
    end
    req4 = 2'b11;
    for (int k = 0; k < 4; k++) exp4 = lfsr_next(exp4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ea = (c == 6) ? 2'b01 : 2'b00;
      tests++;
      if (ack4 !== ea) begin
        fails++; $display("FAIL resetmid_after_ack c=%0d got %b exp %b", c, ack4, ea);
      end
      if (c == 6) begin
        tests++;
        if (data4 !== exp4) begin
          fails++; $display("FAIL resetmid_data got %h exp %h", data4, exp4);
        end
      end
      if (c == 7) begin
        req4 = 2'b00;
        tests++;
        if (wc4 !== 16'd1) begin
          fails++; $display("FAIL resetmid_word_cnt got %h exp 0001", wc4);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_and_drop();
    logic [1:0] r;
    logic [1:0] ea;
    logic [15:0] ewc;
    force u1.word_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u1.word_cnt_q;
    @(negedge clk);
    tests++;
    if (wc1 !== 16'hFFFE) begin
      fails++; $display("FAIL wrap_preload got %h exp fffe", wc1);
    end
    for (int t = 0; t < 2; t++) begin
      r = (t == 0) ? 2'b01 : 2'b10;
      ewc = (t == 0) ? 16'hFFFF : 16'h0000;
      req1 = r;
      exp1 = lfsr_next(exp1);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (t == 0 && c == 1) req1 = 2'b00;
        ea = (c == 3) ? r : 2'b00;
        tests++;
        if (ack1 !== ea) begin
          fails++; $display("FAIL wrap_ack t=%0d c=%0d got %b exp %b", t, c, ack1, ea);
        end
        if (c == 3) begin
          tests++;
          if (data1 !== exp1) begin
            fails++; $display("FAIL wrap_data t=%0d got %h exp %h", t, data1, exp1);
          end
        end
        if (c == 4) begin
          req1 = 2'b00;
          tests++;
          if (wc1 !== ewc) begin
            fails++; $display("FAIL wrap_word_cnt t=%0d got %h exp %h", t, wc1, ewc);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_multi_step();
    test_reset_mid();
    test_wrap_and_drop();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 SHALL have parameter STEPS, default 1, giving the number of LFSR advances per delivered word; legal range 1..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 2 bits: per-requester request level; bit 0 is the plaintext generator, bit 1 is the key generator.
REQ-005 SHALL have port ack, output, 2 bits: per-requester one-cycle pulse meaning data_out is valid for that requester.
REQ-006 SHALL have port data_out, output, 128 bits: registered random word.
REQ-007 SHALL have port lfsr_require, output, 1 bit: advance strobe to the shared LFSR require input.
REQ-008 SHALL have port lfsr_data, input, 128 bits: current LFSR state (random128).
REQ-009 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-010 SHALL have port word_cnt, output, 16 bits: count of words delivered.

Function
REQ-011 SHALL implement an FSM with states IDLE, STEP, CAPTURE and ACK; all outputs SHALL be registered or decoded from state (Moore), and no output SHALL depend combinationally on req.
REQ-012 IDLE: with req==0, stay in IDLE; with any req bit high, latch the winner into owner, load step_cnt=STEPS and go to STEP.
REQ-013 Arbitration SHALL be round-robin: a single request wins outright; when both bits are high, the requester other than last_owner wins; last_owner updates when ACK is entered.
REQ-014 STEP: lfsr_require=1 every STEP cycle; step_cnt decrements each cycle; go to CAPTURE when step_cnt reaches 1 (exactly STEPS require cycles).
REQ-015 CAPTURE: lfsr_require=0; data_out<=lfsr_data at the end of the cycle, reflecting all STEPS advances; then go to ACK.
REQ-016 ACK: ack[owner]=1 for exactly one cycle and the other ack bit stays 0; word_cnt increments, wrapping 0xFFFF to 0x0000; then go to IDLE.
REQ-017 Latency SHALL be fixed: req sampled in IDLE at cycle 0 gives lfsr_require high in cycles 1..STEPS, CAPTURE in cycle STEPS+1 and ack in cycle STEPS+2.
REQ-018 Throughput: one word per STEPS+3 cycles; IDLE always lasts at least one cycle between transactions.
REQ-019 Request rules: a requester SHALL hold req until its ack and drop it the cycle after; req changes after the grant SHALL NOT abort or alter the transaction, and ack SHALL still pulse.
REQ-020 A requester still requesting in the IDLE after a transaction SHALL be treated as a new request and arbitrated normally.
REQ-021 data_out SHALL hold its value from CAPTURE until the next CAPTURE.
REQ-022 lfsr_require SHALL never be high outside STEP, so the LFSR never advances except on behalf of a granted requester.

Reset
REQ-023 On rst sampled high, the block SHALL enter IDLE from any state, including mid-STEP or ACK, with any in-flight transaction discarded and no ack issued for it.
REQ-024 On reset, the following SHALL hold: ack=0, lfsr_require=0, busy=0, data_out=0, word_cnt=0, step_cnt=0, owner=0, last_owner=1 (so requester 0 wins the first tie).
REQ-025 Reset SHALL NOT drive the LFSR's own reset; the LFSR state persists across rst.

Verification
REQ-026 Single request (STEPS=1, req=01 at cycle 0 and held until ack): lfsr_require=1 only in cycle 1, ack=01 only in cycle 3, data_out equals the model LFSR after 1 step, word_cnt=1.
REQ-027 Contention (req=11 held continuously from reset): acks alternate 01, 10, 01, 10 with ack pulses 4 cycles apart (the interval is STEPS+3); each data_out equals successive single-step model LFSR states.
REQ-028 Multi-step (STEPS=4, req=10): lfsr_require is high in cycles 1-4, ack=10 in cycle 6, and data_out equals the model LFSR after 4 steps.
REQ-029 Reset mid-operation (rst high in cycle 2 of a STEPS=4 transaction): in the next cycle busy=0 and lfsr_require=0, no ack is ever issued for it, and a subsequent req=01 is served with requester 0 winning.
REQ-030 Wrap and illegal request (force 65536 deliveries): word_cnt returns to 0x0000; a req drop during STEP still yields ack=01 in cycle STEPS+2; the bench asserts that ack is never 11.
